// File: rtl/regfile_read_arbiter.sv
// Round-robin read-port arbiter: four requesters share one 32:1 register read mux.
// Latency: grant is combinational, response one cycle later. Backpressure: none; one read per cycle.
module regfile_read_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                 clock,
    input  logic                 ctrl_reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [5*NUM_REQ-1:0] req_addr,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [4:0]           port_sel,
    input  logic [31:0]          port_data,
    input  logic                 ctrl_writeEnable,
    input  logic [4:0]           ctrl_writeReg,
    input  logic [31:0]          data_writeReg,
    output logic                 rsp_valid,
    output logic [1:0]           rsp_id,
    output logic [31:0]          rsp_data
);

    logic [1:0]  ptr_q, ptr_d;
    logic        vld_q, vld_d;
    logic [1:0]  id_q, id_d;
    logic [31:0] data_q, data_d;

    logic [4:0]  addr [NUM_REQ];
    logic        gnt_any;
    logic [1:0]  gnt_idx;

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            addr[k] = req_addr[5*k +: 5];
        end
    end

    // Scan requesters starting at the pointer; first asserted one wins.
    always_comb begin
        logic [1:0] idx;
        idx     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr_q + 2'(i);
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
        if (!ctrl_reset) begin
            gnt_any = 1'b0;
        end
    end

    always_comb begin
        gnt      = '0;
        port_sel = '0;
        ptr_d    = ptr_q;
        vld_d    = gnt_any;
        id_d     = id_q;
        data_d   = data_q;
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
            port_sel     = addr[gnt_idx];
            ptr_d        = gnt_idx + 2'd1;
            id_d         = gnt_idx;
            // Register zero reads as zero; a same-cycle write to the selected register is forwarded.
            if (port_sel == 5'd0) begin
                data_d = '0;
            end else if (ctrl_writeEnable && (ctrl_writeReg == port_sel)) begin
                data_d = data_writeReg;
            end else begin
                data_d = port_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            ptr_q  <= '0;
            vld_q  <= 1'b0;
            id_q   <= '0;
            data_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            vld_q  <= vld_d;
            id_q   <= id_d;
            data_q <= data_d;
        end
    end

    assign rsp_valid = vld_q;
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;

endmodule

// File: doc/regfile_read_arbiter.md
REGFILE_READ_ARBITER -- requirements
Module: regfile_read_arbiter

Interface
REQ-001 The block SHALL have one parameter: NUM_REQ, 4, number of requesters; only the value 4 is supported.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 ctrl_reset  input  1  reset, synchronous and active-low.
REQ-004 req  input  4  per-requester read request; bit k belongs to requester k.
REQ-005 req_addr  input  20  read register numbers; requester k at bits [5k+4:5k].
REQ-006 gnt  output  4  one-hot grant, combinational, valid in the same cycle as req.
REQ-007 port_sel  output  5  select driven to the shared 32:1 register read mux.
REQ-008 port_data  input  32  data returned by the shared read mux for port_sel.
REQ-009 ctrl_writeEnable  input  1  register file write strobe, used for forwarding.
REQ-010 ctrl_writeReg  input  5  register file write address.
REQ-011 data_writeReg  input  32  register file write data.
REQ-012 rsp_valid  output  1  registered one-cycle response pulse.
REQ-013 rsp_id  output  2  index of the requester the response belongs to.
REQ-014 rsp_data  output  32  registered read result.

Function
REQ-015 Arbitration SHALL be round-robin over req with a 2-bit priority pointer P; the highest-priority requester is P, then P+1, P+2, P+3 (mod 4).
REQ-016 In any cycle with req != 0 and ctrl_reset high, exactly one gnt bit SHALL be 1: the first asserted requester in priority order.
REQ-017 When req == 0, gnt SHALL be 0, port_sel SHALL be 0, and P SHALL hold.
REQ-018 port_sel SHALL equal req_addr of the granted requester in the grant cycle.
REQ-019 After a grant to requester k, P SHALL become (k+1) mod 4 at the next edge.
REQ-020 Handshake: a requester holds req and req_addr stable until it sees its gnt bit at a clock edge; it deasserts req, or presents a new request, in the following cycle.
REQ-021 Latency: a grant in cycle N SHALL produce rsp_valid=1, rsp_id=k, and rsp_data in cycle N+1 only; a new grant is accepted every cycle, giving a throughput of one read per cycle.
REQ-022 Data selection at the end of grant cycle N, with S = port_sel, is in priority order:
- S == 0: captured value SHALL be 0, regardless of port_data or any write.
- ctrl_writeEnable=1 and ctrl_writeReg == S: captured value SHALL be data_writeReg (write-to-read forwarding).
- otherwise: captured value SHALL be port_data.
REQ-023 In any cycle without a grant, rsp_valid SHALL be 0 in the next cycle.
REQ-024 rsp_id and rsp_data SHALL hold their last values while rsp_valid=0.
REQ-025 Fairness: a requester holding req continuously SHALL be granted within 4 cycles.
REQ-026 Requests whose req bit is 0 SHALL never be granted, whatever their req_addr.

Reset
REQ-027 While ctrl_reset=0, gnt SHALL be forced to 0 and port_sel to 0.
REQ-028 At a rising edge with ctrl_reset=0: P=0, rsp_valid=0, rsp_id=0, rsp_data=0.
REQ-029 Reset mid-operation: a grant made in cycle N, followed by ctrl_reset=0 at the edge ending cycle N, SHALL be discarded; rsp_valid=0 in cycle N+1, and the requester re-requests.
REQ-030 The first cycle with ctrl_reset=1 SHALL arbitrate normally with requester 0 highest priority.

Verification
REQ-031 Reset: ctrl_reset=0 for 2 cycles with req=4'b1111 -> gnt=0, port_sel=0 throughout; after release rsp_valid=0, rsp_id=0, rsp_data=0.
REQ-032 Single read: req=4'b0001, addr0=5, port_data=0xDEADBEEF -> gnt=4'b0001 and port_sel=5 in cycle N; in cycle N+1 rsp_valid=1, rsp_id=0, rsp_data=0xDEADBEEF; in N+2 rsp_valid=0.
REQ-033 Round-robin: req=4'b1111 held from reset -> gnt sequence 0001, 0010, 0100, 1000, 0001; rsp_id sequence 0,1,2,3,0 one cycle later. Then req=4'b1010 with P=1 -> grants 1, 3, 1.
REQ-034 Forwarding:
- req=4'b0010, addr1=7, ctrl_writeEnable=1, ctrl_writeReg=7, data_writeReg=0x12345678, port_data=0 -> rsp_data=0x12345678.
- Same stimulus with ctrl_writeReg=8 -> rsp_data=0.
REQ-035 Register zero: addr=0, port_data=0xFFFFFFFF, ctrl_writeEnable=1, ctrl_writeReg=0, data_writeReg=0xAAAAAAAA -> rsp_data=0.
REQ-036 Mid-operation reset: grant to requester 2 in cycle N with ctrl_reset=0 sampled at the end of N -> rsp_valid=0 in N+1; with req=4'b0110 still held in N+1 (ctrl_reset=1) -> gnt=4'b0010.
